// File: rtl/evaluador_sube_nivel_if.sv
// Signal bundle between the level-up evaluator and the primitive Tamagotchi mode.
// The slave modport is the evaluator's view; master is the consumer/driver side.
interface evaluador_sube_nivel_if;
    logic       activo;
    logic       B_alimentar;
    logic       B_dormir;
    logic       B_jugar;
    logic [1:0] Nivel;
    logic       Entrada_Sube_Nivel;
    logic [2:0] Comida;
    logic [2:0] Energia;
    logic [2:0] Animo;
    logic       Sano;

    modport slave (
        input  activo, B_alimentar, B_dormir, B_jugar, Nivel,
        output Entrada_Sube_Nivel, Comida, Energia, Animo, Sano
    );

    modport master (
        output activo, B_alimentar, B_dormir, B_jugar, Nivel,
        input  Entrada_Sube_Nivel, Comida, Energia, Animo, Sano
    );
endinterface

// File: rtl/evaluador_sube_nivel.sv
// Pet statistics with periodic decay and button refills; emits a one-cycle level-up
// pulse after HOLD_TICKS consecutive healthy ticks, unless the level is already maxed.
module evaluador_sube_nivel #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned DECAY_TICKS = 5,
    parameter int unsigned HOLD_TICKS  = 10,
    parameter int unsigned UMBRAL      = 4,
    parameter int unsigned INC         = 2
) (
    input  logic                         clk,
    input  logic                         B_reset,
    evaluador_sube_nivel_if.slave        bus
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DecW  = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);

    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [DecW-1:0]  DecLast  = DecW'(DECAY_TICKS - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TICKS);
    localparam logic [2:0]       Umbral   = 3'(UMBRAL);

    typedef enum logic [1:0] {StVigilando, StContando, StPulso} state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] cnt_tick_q, cnt_tick_d;
    logic [DecW-1:0]  cnt_decay_q, cnt_decay_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [2:0]       comida_q, comida_d;
    logic [2:0]       energia_q, energia_d;
    logic [2:0]       animo_q, animo_d;
    logic             tick, decay, sano, pulse;

    // Action and decay landing on the same cycle combine into one net, saturated step.
    function automatic logic [2:0] upd(input logic [2:0] v, input logic add, input logic dec);
        int s;
        s = int'(v) + (add ? int'(INC) : 0) - (dec ? 1 : 0);
        if (s > 7) s = 7;
        else if (s < 0) s = 0;
        return 3'(s);
    endfunction

    always_comb begin
        tick  = bus.activo && (cnt_tick_q == TickLast);
        decay = tick && (cnt_decay_q == DecLast);
        sano  = (comida_q >= Umbral) && (energia_q >= Umbral) && (animo_q >= Umbral);

        cnt_tick_d  = cnt_tick_q;
        cnt_decay_d = cnt_decay_q;
        comida_d    = comida_q;
        energia_d   = energia_q;
        animo_d     = animo_q;
        if (bus.activo) begin
            cnt_tick_d = tick ? '0 : cnt_tick_q + 1'b1;
            comida_d   = upd(comida_q, bus.B_alimentar, decay);
            energia_d  = upd(energia_q, bus.B_dormir, decay);
            animo_d    = upd(animo_q, bus.B_jugar, decay);
        end
        if (tick) cnt_decay_d = decay ? '0 : cnt_decay_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pulse   = 1'b0;
        if (bus.activo) begin
            case (state_q)
                StVigilando: begin
                    hold_d = '0;
                    if (tick && sano) begin
                        hold_d  = HoldW'(1);
                        state_d = (HOLD_TICKS <= 1) ? StPulso : StContando;
                    end
                end
                StContando: begin
                    if (tick) begin
                        if (!sano) begin
                            hold_d  = '0;
                            state_d = StVigilando;
                        end else begin
                            hold_d = hold_q + 1'b1;
                            if (hold_q + 1'b1 == HoldLast) state_d = StPulso;
                        end
                    end
                end
                StPulso: begin
                    // At the top level the pulse is swallowed but the cycle still restarts the hold.
                    pulse   = (bus.Nivel != 2'd3);
                    hold_d  = '0;
                    state_d = StVigilando;
                end
                default: begin
                    hold_d  = '0;
                    state_d = StVigilando;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge B_reset) begin
        if (!B_reset) begin
            state_q     <= StVigilando;
            cnt_tick_q  <= '0;
            cnt_decay_q <= '0;
            hold_q      <= '0;
            comida_q    <= 3'd7;
            energia_q   <= 3'd7;
            animo_q     <= 3'd7;
        end else begin
            state_q     <= state_d;
            cnt_tick_q  <= cnt_tick_d;
            cnt_decay_q <= cnt_decay_d;
            hold_q      <= hold_d;
            comida_q    <= comida_d;
            energia_q   <= energia_d;
            animo_q     <= animo_d;
        end
    end

    assign bus.Entrada_Sube_Nivel = pulse;
    assign bus.Comida             = comida_q;
    assign bus.Energia            = energia_q;
    assign bus.Animo              = animo_q;
    assign bus.Sano               = sano;

endmodule
